// File: rtl/poly_reduce_engine.sv
// Coefficient-reduction pass over polynomials in a shared coefficient RAM.
// Barrett reduce or conditional-subtract-q, one coefficient per clock, written back in place.
module poly_reduce_engine #(
   parameter int KYBER_K = 2,
   parameter int KYBER_N = 256,
   parameter int KYBER_Q = 3329,
   parameter int COEF_W  = 16,
   parameter int ADDR_W  = 9,
   parameter int RD_LAT  = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              mode,
   input  logic [1:0]        poly_base,
   input  logic [2:0]        num_polys,
   output logic [ADDR_W-1:0] Coef_RAd,
   output logic              Coef_REN,
   input  logic [COEF_W-1:0] Coef_RData,
   output logic              Coef_WEN,
   output logic [ADDR_W-1:0] Coef_WAd,
   output logic [COEF_W-1:0] Coef_WData,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int LOG_N  = $clog2(KYBER_N);
   localparam int CNT_W  = LOG_N + 3;
   localparam int PIPE_D = RD_LAT + 2;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_FIN   = 2'd3;

   localparam logic [3:0]         K_LIM = 4'(KYBER_K);
   localparam logic signed [31:0] Q_S   = 32'(KYBER_Q);
   localparam logic signed [31:0] Q2_S  = 32'(2 * KYBER_Q);
   localparam logic signed [31:0] BV_S  = 32'(((1 << 26) + KYBER_Q / 2) / KYBER_Q);
   localparam logic signed [31:0] RND_S = 32'sh0200_0000;

   function automatic logic signed [31:0] sext(input logic [COEF_W-1:0] v);
      return {{(32-COEF_W){v[COEF_W-1]}}, v};
   endfunction

   // Quotient estimate comes from the stage-1 product; one conditional add fixes the remainder.
   function automatic logic [COEF_W-1:0] barrett_fin(input logic signed [31:0] x,
                                                     input logic signed [31:0] prod);
      logic signed [31:0] t;
      logic signed [31:0] r;
      t = (prod + RND_S) >>> 26;
      r = x - t * Q_S;
      if (r < 32'sd0) r = r + Q_S;
      else            r = r;
      return COEF_W'(r);
   endfunction

   function automatic logic [COEF_W-1:0] csubq_fin(input logic signed [31:0] x);
      logic signed [31:0] r;
      if (x >= Q_S) r = x - Q_S;
      else          r = x;
      return COEF_W'(r);
   endfunction

   function automatic logic csubq_bad(input logic signed [31:0] x);
      return (x < 32'sd0) || (x >= Q2_S);
   endfunction

   logic [1:0]         state_r;
   logic [1:0]         next_s;
   logic               legal_s;
   logic               accept_s;
   logic               drain_empty_s;
   logic               mode_r;
   logic [CNT_W-1:0]   rem_r;
   logic               ren_r;
   logic [ADDR_W-1:0]  rad_r;
   logic               busy_r;
   logic               done_r;
   logic               err_r;
   logic [RD_LAT-1:0]  rv_r;
   logic               s1_v_r;
   logic [COEF_W-1:0]  s1_x_r;
   logic signed [31:0] s1_prod_r;
   logic               s2_v_r;
   logic [COEF_W-1:0]  s2_data_r;
   logic [ADDR_W-1:0]  apipe_r [PIPE_D];
   logic [COEF_W-1:0]  result_s;
   logic               bad_s;

   // Launch qualification and pipeline-empty detection.
   always_comb begin
      legal_s       = (num_polys != 3'd0) &&
                      (({2'b00, poly_base} + {1'b0, num_polys}) <= K_LIM);
      accept_s      = (state_r == ST_IDLE) && start;
      drain_empty_s = (rv_r == {RD_LAT{1'b0}}) && !s1_v_r;
   end

   // Next-state logic.
   always_comb begin
      next_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               if (legal_s) next_s = ST_RUN;
               else         next_s = ST_FIN;
            end else begin
               next_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (rem_r == {CNT_W{1'b0}}) next_s = ST_DRAIN;
            else                        next_s = ST_RUN;
         end
         ST_DRAIN: begin
            // Stage 2 still holds the last write while this is checked, so done lands right after it.
            if (drain_empty_s) next_s = ST_FIN;
            else               next_s = ST_DRAIN;
         end
         ST_FIN:  next_s = ST_IDLE;
         default: next_s = ST_IDLE;
      endcase
   end

   // FSM state, read address generator and status flags.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= ST_IDLE;
         mode_r  <= 1'b0;
         rem_r   <= {CNT_W{1'b0}};
         ren_r   <= 1'b0;
         rad_r   <= {ADDR_W{1'b0}};
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= next_s;
         done_r  <= (next_s == ST_FIN);
         case (state_r)
            ST_IDLE: begin
               if (accept_s) begin
                  mode_r <= mode;
                  busy_r <= 1'b1;
                  ren_r  <= legal_s;
                  rad_r  <= ADDR_W'(poly_base) << LOG_N;
                  rem_r  <= (CNT_W'(num_polys) << LOG_N) - CNT_W'(1'b1);
               end
            end
            ST_RUN: begin
               if (rem_r == {CNT_W{1'b0}}) begin
                  ren_r <= 1'b0;
               end else begin
                  rad_r <= rad_r + ADDR_W'(1'b1);
                  rem_r <= rem_r - CNT_W'(1'b1);
               end
            end
            ST_FIN:  busy_r <= 1'b0;
            default: busy_r <= busy_r;
         endcase
      end
   end

   // Sticky error: reloaded on launch, set when a bad csubq input enters stage 2.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                         err_r <= 1'b0;
      else if (accept_s)                    err_r <= !legal_s;
      else if (s1_v_r && mode_r && bad_s)   err_r <= 1'b1;
      else                                  err_r <= err_r;
   end

   // Stage-2 arithmetic from the registered stage-1 operands.
   always_comb begin
      result_s = {COEF_W{1'b0}};
      bad_s    = 1'b0;
      if (mode_r) begin
         result_s = csubq_fin(sext(s1_x_r));
         bad_s    = csubq_bad(sext(s1_x_r));
      end else begin
         result_s = barrett_fin(sext(s1_x_r), s1_prod_r);
         bad_s    = 1'b0;
      end
   end

   // Read-latency valid chain, arithmetic stages and the write-address shift register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rv_r      <= {RD_LAT{1'b0}};
         s1_v_r    <= 1'b0;
         s1_x_r    <= {COEF_W{1'b0}};
         s1_prod_r <= 32'sd0;
         s2_v_r    <= 1'b0;
         s2_data_r <= {COEF_W{1'b0}};
         for (int k = 0; k < PIPE_D; k++) apipe_r[k] <= {ADDR_W{1'b0}};
      end else begin
         rv_r[0] <= ren_r;
         for (int k = 1; k < RD_LAT; k++) rv_r[k] <= rv_r[k-1];
         s1_v_r    <= rv_r[RD_LAT-1];
         s1_x_r    <= Coef_RData;
         s1_prod_r <= sext(Coef_RData) * BV_S;
         s2_v_r    <= s1_v_r;
         s2_data_r <= result_s;
         apipe_r[0] <= rad_r;
         for (int k = 1; k < PIPE_D; k++) apipe_r[k] <= apipe_r[k-1];
      end
   end

   assign Coef_REN   = ren_r;
   assign Coef_RAd   = rad_r;
   assign Coef_WEN   = s2_v_r;
   assign Coef_WAd   = apipe_r[PIPE_D-1];
   assign Coef_WData = s2_data_r;
   assign busy       = busy_r;
   assign done       = done_r;
   assign err        = err_r;

endmodule

// File: tb/tb_poly_reduce_engine.sv
// Bench for poly_reduce_engine: two instances (read latency 1 and 3), each with its own RAM model,
// driven by one directed sequence and checked cycle by cycle against a modular-arithmetic model.
module tb_poly_reduce_engine;
   localparam int K = 2, N = 256, Q = 3329, CW = 16, AW = 9;

   logic clk = 1'b0, reset_n = 1'b0, start = 1'b0, mode = 1'b0;
   logic [1:0] poly_base = 2'd0;
   logic [2:0] num_polys = 3'd0;
   logic ren [2], wen [2], busy [2], done [2], err [2];
   logic [AW-1:0] rad [2], wad [2];
   logic [CW-1:0] rdata [2], wdata [2];
   logic [CW-1:0] img [512];
   logic load_req = 1'b0;
   int n_assert = 0, n_fail = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_inst
      localparam int L = 1 + 2 * g;
      logic [CW-1:0] mem [512];
      logic [CW-1:0] rpipe [L];

      poly_reduce_engine #(.KYBER_K(K), .KYBER_N(N), .KYBER_Q(Q), .COEF_W(CW),
                           .ADDR_W(AW), .RD_LAT(L)) dut (
         .clk(clk), .reset_n(reset_n), .start(start), .mode(mode),
         .poly_base(poly_base), .num_polys(num_polys),
         .Coef_RAd(rad[g]), .Coef_REN(ren[g]), .Coef_RData(rdata[g]),
         .Coef_WEN(wen[g]), .Coef_WAd(wad[g]), .Coef_WData(wdata[g]),
         .busy(busy[g]), .done(done[g]), .err(err[g]));

      // RAM with RD_LAT-cycle read pipeline; unread cycles return a marker value.
      always @(posedge clk) begin
         if (load_req) for (int a = 0; a < 512; a++) mem[a] <= img[a];
         else if (wen[g]) mem[wad[g]] <= wdata[g];
         rpipe[0] <= ren[g] ? mem[rad[g]] : 16'hDEAD;
         for (int k = 1; k < L; k++) rpipe[k] <= rpipe[k-1];
      end
      assign rdata[g] = rpipe[L-1];
   end

   function automatic logic [CW-1:0] memrd(input int g, input int a);
      if (g == 0) return g_inst[0].mem[AW'(a)];
      else        return g_inst[1].mem[AW'(a)];
   endfunction

   function automatic int ref_out(input logic m, input logic [CW-1:0] raw);
      int x;
      x = int'($signed(raw));
      if (!m) return ((x % Q) + Q) % Q;
      return (x >= Q) ? x - Q : x;
   endfunction

   function automatic bit bad_in(input logic [CW-1:0] raw);
      int x;
      x = int'($signed(raw));
      return (x < 0) || (x >= 2 * Q);
   endfunction

   task automatic check(input string tag, input longint obs, input longint exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic fill_rand(input int hi);
      for (int a = 0; a < 512; a++)
         img[a] = (hi < 0) ? 16'($urandom()) : 16'($urandom_range(hi, 0));
   endtask

   task automatic preload();
      @(posedge clk); #1 load_req = 1'b1;
      @(posedge clk); #1 load_req = 1'b0;
   endtask

   task automatic run(input logic m, input logic [1:0] b, input logic [2:0] np,
                      input int inj, input int rst_at, input string tag);
      int M, base_a, fb, lim, dc, L, widx, nwr, nmem, stray;
      bit legal, e_ren, e_wen, e_err, stop;
      int bad_rd [2], bad_wr [2], bad_st [2], obs_dc [2];
      logic [CW-1:0] e_wd, e_m;
      legal  = (np >= 3'd1) && (int'(b) + int'(np) <= K);
      M      = legal ? int'(np) * N : 0;
      base_a = int'(b) * N;
      fb     = -1;
      if (legal && m) for (int i = 0; i < M; i++) if (fb < 0 && bad_in(img[base_a + i])) fb = i;
      lim = legal ? M + 9 : 5;
      for (int g = 0; g < 2; g++) begin bad_rd[g] = 0; bad_wr[g] = 0; bad_st[g] = 0; obs_dc[g] = 0; end
      @(posedge clk); #1;
      start = 1'b1; mode = m; poly_base = b; num_polys = np;
      @(posedge clk); #1;
      start = 1'b0; mode = ~m; poly_base = ~b; num_polys = 3'($urandom_range(7, 0));
      stop = 1'b0;
      for (int cyc = 1; cyc <= lim && !stop; cyc++) begin
         if (cyc == inj) begin
            start = 1'b1; mode = ~m; poly_base = (b == 2'd0) ? 2'd1 : 2'd0; num_polys = 3'd1;
         end else begin
            start = 1'b0;
         end
         if (cyc == rst_at) reset_n = 1'b0;
         @(negedge clk);
         if (cyc == rst_at) begin
            for (int g = 0; g < 2; g++)
               check($sformatf("%s/L%0d outputs_in_reset", tag, 1 + 2 * g),
                     longint'({ren[g], rad[g], wen[g], wad[g], wdata[g], busy[g], done[g], err[g]}), 0);
            stop = 1'b1;
         end else begin
            for (int g = 0; g < 2; g++) begin
               L     = 1 + 2 * g;
               dc    = legal ? M + L + 3 : 1;
               e_ren = (cyc <= M);
               e_wen = (cyc >= L + 3) && (cyc <= M + L + 2);
               e_err = legal ? (fb >= 0 && cyc >= fb + L + 3) : 1'b1;
               if (ren[g] !== e_ren || (e_ren && rad[g] !== AW'(base_a + cyc - 1))) bad_rd[g]++;
               if (e_wen) begin
                  widx = base_a + cyc - L - 3;
                  e_wd = 16'(ref_out(m, img[widx]));
                  if (wen[g] !== 1'b1 || wad[g] !== AW'(widx) || wdata[g] !== e_wd) bad_wr[g]++;
               end else if (wen[g] !== 1'b0) begin
                  bad_wr[g]++;
               end
               if (busy[g] !== (cyc <= dc) || done[g] !== (cyc == dc) || err[g] !== e_err) bad_st[g]++;
               if (done[g] === 1'b1 && obs_dc[g] == 0) obs_dc[g] = cyc;
            end
            @(posedge clk); #1;
         end
      end
      if (rst_at > 0) begin
         stray = 0;
         @(posedge clk); #1 reset_n = 1'b1;
         for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            for (int g = 0; g < 2; g++) if (done[g] !== 1'b0 || wen[g] !== 1'b0) stray++;
         end
         check({tag, " no_done_after_reset"}, stray, 0);
      end else begin
         for (int g = 0; g < 2; g++) begin
            L = 1 + 2 * g;
            check($sformatf("%s/L%0d read_seq_bad_cycles", tag, L), bad_rd[g], 0);
            check($sformatf("%s/L%0d write_seq_bad_cycles", tag, L), bad_wr[g], 0);
            check($sformatf("%s/L%0d status_bad_cycles", tag, L), bad_st[g], 0);
            check($sformatf("%s/L%0d done_cycle", tag, L), obs_dc[g], legal ? M + L + 3 : 1);
         end
      end
      for (int g = 0; g < 2; g++) begin
         L    = 1 + 2 * g;
         nwr  = (rst_at > 0) ? rst_at - L - 3 : M;
         nmem = 0;
         for (int a = 0; a < 512; a++) begin
            e_m = (legal && a >= base_a && a - base_a < nwr) ? 16'(ref_out(m, img[a])) : img[a];
            if (memrd(g, a) !== e_m) nmem++;
         end
         check($sformatf("%s/L%0d ram_bad_words", tag, L), nmem, 0);
      end
   endtask

   initial begin
      int e1 [4];
      int e4 [5];
      int sel;
      e1 = '{3328, 0, 2806, 522};
      e4 = '{3328, 0, 3328, 3329, 65531};
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      for (int g = 0; g < 2; g++)
         check($sformatf("reset_state/L%0d", 1 + 2 * g),
               longint'({ren[g], rad[g], wen[g], wad[g], wdata[g], busy[g], done[g], err[g]}), 0);
      reset_n = 1'b1;

      fill_rand(-1);
      img[0] = 16'hFFFF; img[1] = 16'd3329; img[2] = 16'h7FFF; img[3] = 16'h8000;
      preload();
      run(1'b0, 2'd0, 3'd1, 0, 0, "barrett_b0");
      for (int g = 0; g < 2; g++) begin
         for (int i = 0; i < 4; i++) check($sformatf("barrett_edge[%0d]/g%0d", i, g), memrd(g, i), e1[i]);
         check($sformatf("barrett_err/g%0d", g), err[g], 0);
      end

      fill_rand(-1); preload(); run(1'b0, 2'd1, 3'd1, 0, 0, "barrett_b1");
      fill_rand(-1); preload(); run(1'b0, 2'd0, 3'd2, 0, 0, "barrett_n2");

      fill_rand(6657);
      img[0] = 16'd3328; img[1] = 16'd3329; img[2] = 16'd6657; img[3] = 16'd6658; img[4] = 16'hFFFB;
      preload();
      run(1'b1, 2'd0, 3'd1, 0, 0, "csubq");
      for (int g = 0; g < 2; g++) begin
         for (int i = 0; i < 5; i++) check($sformatf("csubq_val[%0d]/g%0d", i, g), memrd(g, i), e4[i]);
         check($sformatf("csubq_err_sticky/g%0d", g), err[g], 1);
      end

      fill_rand(-1); preload(); run(1'b1, 2'd1, 3'd1, 0, 0, "csubq_rand");
      fill_rand(-1); preload(); run(1'b0, 2'd0, 3'd1, 50, 0, "start_ignored");
      fill_rand(-1); preload(); run(1'b1, 2'd1, 3'd1, 0, 100, "reset_mid");
      fill_rand(-1); preload(); run(1'b0, 2'd0, 3'd1, 0, 0, "after_reset");

      preload(); run(1'b0, 2'd0, 3'd0, 0, 0, "illegal_n0");
      preload(); run(1'b1, 2'd2, 3'd1, 0, 0, "illegal_b2");
      preload(); run(1'b0, 2'd1, 3'd2, 0, 0, "illegal_b1n2");

      for (int r = 0; r < 3; r++) begin
         sel = $urandom_range(2, 0);
         fill_rand(-1); preload();
         run(1'($urandom_range(1, 0)), (sel == 1) ? 2'd1 : 2'd0, (sel == 2) ? 3'd2 : 3'd1,
             0, 0, $sformatf("random%0d", r));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
